// File: rtl/stack_call_sequencer.sv
// Stack call/return sequencer: steps CALL, RET, INT and RTI through their stack
// pushes and pops, owns the stack pointer, then loads PC (and flags for RTI).
// Optional build macro: STACK_BOUNDS_CHECK_EN adds overflow/underflow detection
// with a sticky stack_err_o; without it the stack pointer wraps silently.
module stack_call_sequencer #(
    parameter int unsigned        ADDR_W  = 12,
    parameter int unsigned        PC_W    = 32,
    parameter logic [ADDR_W-1:0]  SP_INIT = ADDR_W'((1 << ADDR_W) - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [PC_W-1:0]   pc_ret_i,
    input  logic [PC_W-1:0]   target_i,
    input  logic [2:0]        flags_in_i,
    input  logic [15:0]       mem_rdata_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] sp_o,
    output logic              pc_load_o,
    output logic [PC_W-1:0]   pc_out_o,
    output logic              flags_load_o,
    output logic [2:0]        flags_out_o,
    output logic              done_o,
    output logic              stack_err_o
);

    typedef enum logic [1:0] {OpCall, OpRet, OpInt, OpRti} op_e;

    typedef enum logic [3:0] {
        StIdle, StPushF, StPushH, StPushL, StPopL, StPopH, StPopF, StCapt, StLoad
    } state_e;

    state_e            state_q, state_d, next_st;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0]   pc_ret_q, pc_ret_d, target_q, target_d, pc_out_q, pc_out_d;
    logic [2:0]        flags_q, flags_d, flags_out_q, flags_out_d;
    logic [15:0]       lo_q, lo_d, hi_q, hi_d, push_data, hi_sel;
    logic [31:0]       pc_ret_w;
    logic              push_req, pop_req, stack_full, stack_empty;

    // Return address is always saved as two 16-bit halves
    assign pc_ret_w    = 32'(pc_ret_q);
    assign sp_o        = sp_q;
    assign pc_out_o    = pc_out_q;
    assign flags_out_o = flags_out_q;

`ifdef STACK_BOUNDS_CHECK_EN
    logic err_q, err_d;

    assign stack_full  = (sp_q == '0);
    assign stack_empty = (sp_q == SP_INIT);
    assign err_d       = err_q | (push_req & stack_full) | (pop_req & stack_empty);
    assign stack_err_o = err_q;

    // Sticky bounds error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
    assign stack_err_o = 1'b0;
`endif

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpCall;
            sp_q        <= SP_INIT;
            pc_ret_q    <= '0;
            target_q    <= '0;
            flags_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            pc_out_q    <= '0;
            flags_out_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sp_q        <= sp_d;
            pc_ret_q    <= pc_ret_d;
            target_q    <= target_d;
            flags_q     <= flags_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            pc_out_q    <= pc_out_d;
            flags_out_q <= flags_out_d;
        end
    end

    // Next-state, stack traffic and strobes
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sp_d         = sp_q;
        pc_ret_d     = pc_ret_q;
        target_d     = target_q;
        flags_d      = flags_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        pc_out_d     = pc_out_q;
        flags_out_d  = flags_out_q;
        next_st      = StIdle;
        push_req     = 1'b0;
        pop_req      = 1'b0;
        push_data    = '0;
        hi_sel       = mem_rdata_i;
        busy_o       = (state_q != StIdle);
        mem_addr_o   = sp_q;
        mem_wdata_o  = '0;
        mem_we_o     = 1'b0;
        mem_re_o     = 1'b0;
        pc_load_o    = 1'b0;
        flags_load_o = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d     = op_e'(op_i);
                    pc_ret_d = pc_ret_i;
                    target_d = target_i;
                    flags_d  = flags_in_i;
                    unique case (op_e'(op_i))
                        OpCall:       state_d = StPushH;
                        OpInt:        state_d = StPushF;
                        OpRet, OpRti: state_d = StPopL;
                    endcase
                end
            end
            StPushF: begin
                push_req  = 1'b1;
                push_data = {13'b0, flags_q};
                next_st   = StPushH;
            end
            StPushH: begin
                push_req  = 1'b1;
                push_data = pc_ret_w[31:16];
                next_st   = StPushL;
            end
            StPushL: begin
                push_req  = 1'b1;
                push_data = pc_ret_w[15:0];
                next_st   = StLoad;
            end
            StPopL: begin
                pop_req = 1'b1;
                next_st = StPopH;
            end
            StPopH: begin
                // Read data here answers the POP_L read
                pop_req = 1'b1;
                lo_d    = mem_rdata_i;
                next_st = (op_q == OpRti) ? StPopF : StCapt;
            end
            StPopF: begin
                pop_req = 1'b1;
                hi_d    = mem_rdata_i;
                next_st = StCapt;
            end
            StCapt: begin
                // RET: last read is the high half; RTI: last read is the flag word
                if (op_q == OpRti) begin
                    hi_sel      = hi_q;
                    flags_out_d = mem_rdata_i[2:0];
                end
                pc_out_d = PC_W'({hi_sel, lo_q});
                state_d  = StLoad;
            end
            StLoad: begin
                pc_load_o    = 1'b1;
                flags_load_o = (op_q == OpRti);
                done_o       = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A bounds hit suppresses the access and ends the operation without a PC load
        if (push_req) begin
            if (stack_full) begin
                done_o  = 1'b1;
                state_d = StIdle;
            end else begin
                mem_we_o    = 1'b1;
                mem_wdata_o = push_data;
                sp_d        = sp_q - ADDR_W'(1);
                state_d     = next_st;
                if (next_st == StLoad) begin
                    pc_out_d = target_q;
                end
            end
        end
        if (pop_req) begin
            if (stack_empty) begin
                done_o  = 1'b1;
                state_d = StIdle;
            end else begin
                mem_re_o   = 1'b1;
                mem_addr_o = sp_q + ADDR_W'(1);
                sp_d       = sp_q + ADDR_W'(1);
                state_d    = next_st;
            end
        end
    end

endmodule

// File: doc/stack_call_sequencer.md
Name: stack_call_sequencer

Overview:
- Multi-cycle sequencer for CALL, RET, INT and RTI.
- Owns the stack pointer and drives the data-memory port during stack traffic.
- Stalls fetch/decode while busy, then loads PC (and flags for RTI) in one cycle.
- Sits beside the decode/control stage; decode pulses start with an op code and the operands.

Parameters:
- ADDR_W, 12, data-memory word-address width.
- PC_W, 32, program counter width; saved to the stack as two 16-bit halves.
- SP_INIT, (1<<ADDR_W)-1, stack pointer value after reset (stack grows down).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from decode; sampled only in IDLE.
- op  in  2  00 CALL, 01 RET, 10 INT, 11 RTI.
- pc_ret  in  PC_W  return address to push (already PC+1).
- target  in  PC_W  jump target for CALL/INT.
- flags_in  in  3  {Z,N,C} to push on INT.
- mem_rdata  in  16  data-memory read data, valid the cycle after mem_re.
- busy  out  1  high in every non-IDLE state; stalls fetch and decode.
- mem_addr  out  ADDR_W  stack access address.
- mem_wdata  out  16  push data.
- mem_we  out  1  push strobe.
- mem_re  out  1  pop strobe.
- sp  out  ADDR_W  current stack pointer.
- pc_load  out  1  one-cycle PC load strobe.
- pc_out  out  PC_W  new PC value.
- flags_load  out  1  one-cycle flag restore strobe (RTI only).
- flags_out  out  3  restored {Z,N,C}.
- done  out  1  one-cycle completion pulse.
- stack_err  out  1  sticky overflow/underflow error.

Behaviour:
- Reset values: state=IDLE, sp=SP_INIT, all strobes 0, pc_out=0, flags_out=0, stack_err=0. Reset mid-operation aborts with no PC load.
- Stack convention: sp points to the next free word.
  - Push: addr=sp, we=1, sp<=sp-1.
  - Pop: addr=sp+1, re=1, sp<=sp+1.
- In IDLE with start=1: latch op, pc_ret, target and flags_in; go to the first state; busy=1 from the next cycle. start while busy is ignored.
- CALL: PUSH_H (pc_ret[31:16]) -> PUSH_L (pc_ret[15:0]) -> LOAD (pc_out=target).
- INT: PUSH_F (wdata={13'b0,flags}) -> PUSH_H -> PUSH_L -> LOAD (pc_out=target).
- RET: POP_L -> POP_H (capture rdata as low half) -> CAPT (capture high half) -> LOAD (pc_out={hi,lo}).
- RTI: POP_L -> POP_H -> POP_F -> CAPT (capture rdata[2:0] as flags) -> LOAD (pc_load and flags_load).
- LOAD: pc_load=1, done=1, then return to IDLE.
- Latency, start-high cycle to pc_load: CALL 3, INT 4, RET 4, RTI 5 cycles.
- pc_out and flags_out are registered and hold their value until the next LOAD.
- Exactly one of mem_we/mem_re is high per stack state; both are 0 in IDLE, CAPT and LOAD.
- Widths: sp arithmetic is modulo 2^ADDR_W; pop data uses the low 16 bits of mem_rdata only.

Optional Feature:
- Macro STACK_BOUNDS_CHECK_EN.
- Defined:
  - A push with sp==0 sets stack_err; the pop condition is sp==SP_INIT.
  - On either condition: no memory strobe and no sp change that cycle; go straight to IDLE with done=1 and pc_load=0.
  - stack_err stays 1 until rst.
- Not defined: sp wraps silently and stack_err is tied 0.

Test Plan:
- CALL, pc_ret=0x00012345, target=0x00000200, sp=0xFFF -> writes 0x0001@0xFFF, 0x2345@0xFFE; pc_load with pc_out=0x200 on cycle 3; sp=0xFFD.
- RET after the above, with memory returning 0x2345 then 0x0001 -> reads @0xFFE, 0xFFF; pc_out=0x00012345 on cycle 4; sp=0xFFF.
- INT, flags=3'b101, pc_ret=0x10, target=0x0 -> writes 0x0005@0xFFF, 0x0000@0xFFE, 0x0010@0xFFD; then RTI restores pc_out=0x10, flags_out=3'b101, sp=0xFFF.
- start pulsed again while busy during CALL -> ignored; only one pc_load, sp decremented by 2.
- rst asserted during PUSH_L of CALL -> immediate IDLE, sp=0xFFF, no pc_load, busy=0.
- With STACK_BOUNDS_CHECK_EN: RET with sp=0xFFF -> no mem_re, done=1, pc_load=0, stack_err=1 and held.
